// File: rtl/nv_nvdla_hs_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | nv_nvdla_hs_pkg : shared types and defaults for the req/ack source   |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
package nv_nvdla_hs_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        REQ_HI = 2'd1,
        REQ_LO = 2'd2
    } hs_state_e;

    localparam int unsigned HS_TO_CYC_DEFAULT = 1024;

    // Bits needed to hold a count of 0..cyc-1 (at least one bit).
    function automatic int unsigned to_cnt_width(input int unsigned cyc);
        return (cyc > 1) ? $clog2(cyc) : 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/nv_nvdla_hs_req_src_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | nv_nvdla_hs_req_src_if : event port, req/ack pair and status signals |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
interface nv_nvdla_hs_req_src_if #(
    parameter int DW    = 8,
    parameter int CNT_W = 16
) ();
    logic             evt_valid;
    logic [DW-1:0]    evt_data;
    logic             evt_ready;
    logic             req_o;
    logic [DW-1:0]    data_o;
    logic             ack_i;
    logic             done_o;
    logic             busy_o;
    logic [CNT_W-1:0] xfer_cnt;
    logic             err_o;
    logic             err_clr;

    // master: the request source itself; slave: producer plus ack return path.
    modport master (
        input  evt_valid, evt_data, ack_i, err_clr,
        output evt_ready, req_o, data_o, done_o, busy_o, xfer_cnt, err_o
    );
    modport slave (
        output evt_valid, evt_data, ack_i, err_clr,
        input  evt_ready, req_o, data_o, done_o, busy_o, xfer_cnt, err_o
    );
endinterface
`default_nettype wire

// File: rtl/nv_nvdla_hs_timeout.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | nv_nvdla_hs_timeout : saturating phase timer, cleared on state entry |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
module nv_nvdla_hs_timeout
    import nv_nvdla_hs_pkg::*;
#(
    parameter int unsigned TO_CYC = HS_TO_CYC_DEFAULT
) (
    input  wire logic i_clk,
    input  wire logic i_rst,
    input  wire logic clr_i,
    input  wire logic en_i,
    output logic      reached_o
);
    localparam int unsigned CW = to_cnt_width(TO_CYC);

    generate
        if (TO_CYC == 0) begin : g_disabled
            logic unused_in;
            assign unused_in = ^{i_clk, i_rst, clr_i, en_i};
            assign reached_o = 1'b0;
        end else begin : g_enabled
            localparam logic [CW-1:0] LAST = CW'(TO_CYC - 1);
            logic [CW-1:0] cnt_q, cnt_d;
            logic          at_last;

            assign at_last = (cnt_q == LAST);

            // Saturating at LAST keeps reached_o asserted for as long as the phase stalls.
            always_comb begin
                cnt_d = cnt_q;
                if (clr_i)
                    cnt_d = '0;
                else if (en_i && !at_last)
                    cnt_d = cnt_q + CW'(1);
            end

            always_ff @(posedge i_clk) begin
                if (i_rst) cnt_q <= '0;
                else       cnt_q <= cnt_d;
            end

            assign reached_o = en_i && at_last;
        end
    endgenerate
endmodule
`default_nettype wire

// File: rtl/nv_nvdla_hs_req_src.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | nv_nvdla_hs_req_src : four-phase request source with one-entry hold  |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
module nv_nvdla_hs_req_src
    import nv_nvdla_hs_pkg::*;
#(
    parameter int          DW     = 8,
    parameter int          CNT_W  = 16,
    parameter int unsigned TO_CYC = HS_TO_CYC_DEFAULT
) (
    input  wire logic             i_clk,
    input  wire logic             i_rst,
    nv_nvdla_hs_req_src_if.master hs
);
    hs_state_e        state_q, state_d;
    logic             hold_vld_q, hold_vld_d;
    logic [DW-1:0]    hold_data_q, hold_data_d;
    logic             req_q, req_d;
    logic [DW-1:0]    data_q, data_d;
    logic             done_q, done_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             err_q, err_d;
    logic             launch, accept, to_reached;

    // A stale acknowledge in IDLE blocks launch so it cannot complete a new transfer.
    assign launch       = (state_q == IDLE) && hold_vld_q && !hs.ack_i;
    assign hs.evt_ready = !hold_vld_q || launch;
    assign accept       = hs.evt_valid && hs.evt_ready;

    always_comb begin
        state_d     = state_q;
        req_d       = req_q;
        data_d      = data_q;
        done_d      = 1'b0;
        cnt_d       = cnt_q;
        hold_vld_d  = hold_vld_q;
        hold_data_d = hold_data_q;

        if (accept) begin
            hold_vld_d  = 1'b1;
            hold_data_d = hs.evt_data;
        end else if (launch) begin
            hold_vld_d  = 1'b0;
        end

        case (state_q)
            IDLE: begin
                if (launch) begin
                    state_d = REQ_HI;
                    req_d   = 1'b1;
                    data_d  = hold_data_q;
                end
            end
            REQ_HI: begin
                if (hs.ack_i) begin
                    state_d = REQ_LO;
                    req_d   = 1'b0;
                end
            end
            REQ_LO: begin
                if (!hs.ack_i) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                    cnt_d   = cnt_q + CNT_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
                req_d   = 1'b0;
            end
        endcase

        // Setting wins over a simultaneous clear.
        err_d = to_reached ? 1'b1 : (hs.err_clr ? 1'b0 : err_q);
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= IDLE;
            hold_vld_q  <= 1'b0;
            hold_data_q <= '0;
            req_q       <= 1'b0;
            data_q      <= '0;
            done_q      <= 1'b0;
            cnt_q       <= '0;
            err_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            hold_vld_q  <= hold_vld_d;
            hold_data_q <= hold_data_d;
            req_q       <= req_d;
            data_q      <= data_d;
            done_q      <= done_d;
            cnt_q       <= cnt_d;
            err_q       <= err_d;
        end
    end

    nv_nvdla_hs_timeout #(
        .TO_CYC    (TO_CYC)
    ) u_timeout (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .clr_i     (state_d != state_q),
        .en_i      (state_q != IDLE),
        .reached_o (to_reached)
    );

    assign hs.req_o    = req_q;
    assign hs.data_o   = data_q;
    assign hs.done_o   = done_q;
    assign hs.xfer_cnt = cnt_q;
    assign hs.err_o    = err_q;
    assign hs.busy_o   = (state_q != IDLE) || hold_vld_q;
endmodule
`default_nettype wire

// File: tb/tb_nv_nvdla_hs_req_src.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_nv_nvdla_hs_req_src : directed + randomized bench, scoreboard     |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_nv_nvdla_hs_req_src;
    localparam int DW     = 8;
    localparam int CNT_W  = 2;
    localparam int TO_CYC = 16;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    nv_nvdla_hs_req_src_if #(.DW(DW), .CNT_W(CNT_W)) hs ();

    nv_nvdla_hs_req_src #(.DW(DW), .CNT_W(CNT_W), .TO_CYC(TO_CYC)) dut (
        .i_clk (clk),
        .i_rst (rst),
        .hs    (hs)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Transaction-level reference: accepted payloads in order, completions modulo 2^CNT_W.
    logic [DW-1:0] exp_q[$];
    int            exp_cnt = 0;
    logic          prev_req = 1'b0, prev_done = 1'b0, rst_seen = 1'b1;
    logic [DW-1:0] prev_data = '0;

    always @(negedge clk) begin
        if (rst) begin
            exp_q.delete();
            exp_cnt  = 0;
            rst_seen = 1'b1;
        end else begin
            if (hs.done_o) begin
                exp_cnt = (exp_cnt + 1) % (1 << CNT_W);
                check("done_pulse_width", prev_done, 0);
            end
            check("xfer_cnt", hs.xfer_cnt, exp_cnt);
            if (!rst_seen) begin
                if (hs.req_o && !prev_req) begin
                    if (exp_q.size() == 0) check("launch_without_event", 1, 0);
                    else                   check("launch_data", hs.data_o, exp_q.pop_front());
                end else begin
                    check("data_stable", hs.data_o, prev_data);
                end
            end
            if (hs.evt_valid && hs.evt_ready) exp_q.push_back(hs.evt_data);
            rst_seen = 1'b0;
        end
        prev_req  = hs.req_o;
        prev_done = hs.done_o;
        prev_data = hs.data_o;
    end

    task automatic offer(input logic [DW-1:0] d);
        int k;
        hs.evt_data  = d;
        hs.evt_valid = 1'b1;
        k = 0;
        while (!hs.evt_ready && k < 200) begin
            tick();
            k++;
        end
        if (k >= 200) check("offer_timeout", 0, 1);
        tick();
        hs.evt_valid = 1'b0;
    endtask

    // Plays the far side: raise ack after hi cycles of req, drop it lo cycles after req falls.
    task automatic complete_hs(input int hi, input int lo);
        int k;
        k = 0;
        while (!hs.req_o && k < 300) begin tick(); k++; end
        if (k >= 300) check("req_rise_timeout", 0, 1);
        repeat (hi) tick();
        hs.ack_i = 1'b1;
        k = 0;
        while (hs.req_o && k < 300) begin tick(); k++; end
        if (k >= 300) check("req_fall_timeout", 0, 1);
        repeat (lo) tick();
        hs.ack_i = 1'b0;
        tick();
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog expired got=running exp=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int   idx, k;
        logic acc;
        hs.evt_valid = 1'b0;
        hs.evt_data  = '0;
        hs.ack_i     = 1'b0;
        hs.err_clr   = 1'b0;
        repeat (3) tick();
        check("rst_req",   hs.req_o,     0);
        check("rst_data",  hs.data_o,    0);
        check("rst_done",  hs.done_o,    0);
        check("rst_err",   hs.err_o,     0);
        check("rst_cnt",   hs.xfer_cnt,  0);
        check("rst_busy",  hs.busy_o,    0);
        check("rst_ready", hs.evt_ready, 1);
        rst = 1'b0;
        tick();

        // Single event
        hs.evt_data = 8'hA5; hs.evt_valid = 1'b1;
        tick();
        hs.evt_valid = 1'b0;
        check("single_busy_hold", hs.busy_o, 1);
        check("single_req_early", hs.req_o,  0);
        tick();
        check("single_req",  hs.req_o,  1);
        check("single_data", hs.data_o, 8'hA5);
        repeat (4) tick();
        hs.ack_i = 1'b1;
        repeat (4) tick();
        check("single_req_drop", hs.req_o, 0);
        hs.ack_i = 1'b0;
        tick();
        check("single_done", hs.done_o,   1);
        check("single_cnt",  hs.xfer_cnt, 1);
        tick();
        check("single_done_off", hs.done_o, 0);
        check("single_idle",     hs.busy_o, 0);

        // Stale acknowledge
        hs.ack_i = 1'b1;
        hs.evt_data = 8'h3C; hs.evt_valid = 1'b1;
        tick();
        hs.evt_valid = 1'b0;
        repeat (4) tick();
        check("stale_no_req", hs.req_o,  0);
        check("stale_busy",   hs.busy_o, 1);
        hs.ack_i = 1'b0;
        tick();
        check("stale_req",  hs.req_o,  1);
        check("stale_data", hs.data_o, 8'h3C);
        complete_hs(1, 1);
        check("stale_done", hs.done_o,   1);
        check("stale_cnt",  hs.xfer_cnt, 2);

        // Timeout
        hs.evt_data = 8'h5A; hs.evt_valid = 1'b1;
        tick();
        hs.evt_valid = 1'b0;
        tick();
        check("to_req", hs.req_o, 1);
        repeat (TO_CYC - 1) tick();
        check("to_err_early", hs.err_o, 0);
        tick();
        check("to_err_set",  hs.err_o, 1);
        check("to_req_held", hs.req_o, 1);
        hs.err_clr = 1'b1;
        tick();
        hs.err_clr = 1'b0;
        check("to_clr_while_wait", hs.err_o, 1);
        hs.ack_i = 1'b1;
        tick();
        check("to_req_drop", hs.req_o, 0);
        repeat (2) tick();
        hs.ack_i = 1'b0;
        tick();
        check("to_done",   hs.done_o, 1);
        check("to_sticky", hs.err_o,  1);
        hs.err_clr = 1'b1;
        tick();
        hs.err_clr = 1'b0;
        check("to_cleared", hs.err_o, 0);

        // Reset mid-REQ_HI
        hs.evt_data = 8'h77; hs.evt_valid = 1'b1;
        tick();
        hs.evt_valid = 1'b0;
        tick();
        check("mid_req", hs.req_o, 1);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check("mid_rst_req",   hs.req_o,     0);
        check("mid_rst_data",  hs.data_o,    0);
        check("mid_rst_busy",  hs.busy_o,    0);
        check("mid_rst_ready", hs.evt_ready, 1);
        check("mid_rst_cnt",   hs.xfer_cnt,  0);

        // Back-to-back with evt_valid held high
        fork
            begin
                idx = 0; k = 0;
                hs.evt_data = 8'h01; hs.evt_valid = 1'b1;
                while (idx < 3 && k < 300) begin
                    acc = hs.evt_ready;
                    tick();
                    k++;
                    if (acc) begin
                        idx++;
                        if (idx == 2) check("b2b_ready_drop", hs.evt_ready, 0);
                        hs.evt_data = 8'(idx + 1);
                    end
                end
                hs.evt_valid = 1'b0;
                if (idx < 3) check("b2b_accept_timeout", idx, 3);
            end
            begin
                repeat (3) complete_hs(2, 1);
            end
        join
        check("b2b_cnt", hs.xfer_cnt, 3);

        // Counter wrap: five handshakes from reset
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            offer(8'(i * 17 + 3));
            complete_hs(1, 1);
        end
        check("wrap_cnt", hs.xfer_cnt, 1);

        // Randomized traffic
        fork
            begin
                for (int i = 0; i < 40; i++) begin
                    repeat ($urandom_range(0, 4)) tick();
                    offer(8'($urandom));
                end
            end
            begin
                for (int i = 0; i < 40; i++)
                    complete_hs($urandom_range(0, 5), $urandom_range(0, 5));
            end
        join
        repeat (2) tick();
        check("rand_cnt",   hs.xfer_cnt,  exp_cnt);
        check("rand_drain", exp_q.size(), 0);
        check("rand_idle",  hs.busy_o,    0);
        check("rand_noerr", hs.err_o,     0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
`default_nettype wire
